// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter_if : one requester's request / grant / read-return bundle   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 16
);
  logic                       req;
  logic                       wr;
  logic [DATA_ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]      wdata;
  logic                       gnt;
  logic                       rvalid;
  logic [DATA_WIDTH-1:0]      rdata;

  modport master (output req, wr, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, wr, addr, wdata, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter : round-robin core/host arbiter for the single-port data RAM |
// | Optional host lock (LOCKED state, host_lock port) via DMEM_ARB_LOCK_EN.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 16
) (
  input  wire                        clk,
  input  wire                        rst,
  dmem_arbiter_if.slave              core,
  dmem_arbiter_if.slave              host,
`ifdef DMEM_ARB_LOCK_EN
  input  wire                        host_lock,
`endif
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  wire  [DATA_WIDTH-1:0]      mem_rdata
);

  typedef enum logic [0:0] {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  state_t                     state;
  logic                       rr_last;
  logic                       core_gnt;
  logic                       host_gnt;
  logic                       core_xfer;
  logic                       host_xfer;
  logic                       any_xfer;
  logic                       win;
  logic                       win_wr;
  logic [DATA_ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0]      win_wdata;
  logic                       s1_valid;
  logic                       s1_port;
  logic                       s2_valid;
  logic                       s2_port;
  logic                       core_rvalid_reg;
  logic                       host_rvalid_reg;
  logic [DATA_WIDTH-1:0]      core_rdata_reg;
  logic [DATA_WIDTH-1:0]      host_rdata_reg;

`ifdef DMEM_ARB_LOCK_EN
  state_t state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_OPEN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OPEN:   if (host_xfer && host_lock) state_nxt = ST_LOCKED;
      ST_LOCKED: if (!host_lock)             state_nxt = ST_OPEN;
      default:                               state_nxt = ST_OPEN;
    endcase
  end
`else
  assign state = ST_OPEN;
`endif

  // Grants are gated by reset so nothing is granted while rst is low.
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (rst) begin
      if (state == ST_LOCKED) begin
        host_gnt = host.req;
      end else if (core.req && host.req) begin
        core_gnt = (rr_last == PORT_HOST);
        host_gnt = (rr_last == PORT_CORE);
      end else begin
        core_gnt = core.req;
        host_gnt = host.req;
      end
    end
  end

  assign core.gnt  = core_gnt;
  assign host.gnt  = host_gnt;
  assign core_xfer = core.req & core_gnt;
  assign host_xfer = host.req & host_gnt;
  assign any_xfer  = core_xfer | host_xfer;
  assign win       = host_xfer ? PORT_HOST : PORT_CORE;
  assign win_wr    = host_xfer ? host.wr    : core.wr;
  assign win_addr  = host_xfer ? host.addr  : core.addr;
  assign win_wdata = host_xfer ? host.wdata : core.wdata;

  // Read tag travels two stages to line up with the RAM's registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last   <= PORT_HOST;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      s1_valid  <= 1'b0;
      s1_port   <= PORT_CORE;
      s2_valid  <= 1'b0;
      s2_port   <= PORT_CORE;
    end else begin
      mem_en   <= any_xfer;
      mem_we   <= any_xfer & win_wr;
      if (any_xfer) begin
        rr_last   <= win;
        mem_addr  <= win_addr;
        mem_wdata <= win_wdata;
      end
      s1_valid <= any_xfer & ~win_wr;
      s1_port  <= win;
      s2_valid <= s1_valid;
      s2_port  <= s1_port;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rvalid_reg <= 1'b0;
      host_rvalid_reg <= 1'b0;
      core_rdata_reg  <= '0;
      host_rdata_reg  <= '0;
    end else begin
      core_rvalid_reg <= s2_valid && (s2_port == PORT_CORE);
      host_rvalid_reg <= s2_valid && (s2_port == PORT_HOST);
      if (s2_valid && (s2_port == PORT_CORE)) core_rdata_reg <= mem_rdata;
      if (s2_valid && (s2_port == PORT_HOST)) host_rdata_reg <= mem_rdata;
    end
  end

  assign core.rvalid = core_rvalid_reg;
  assign host.rvalid = host_rvalid_reg;
  assign core.rdata  = core_rdata_reg;
  assign host.rdata  = host_rdata_reg;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_arbiter : randomized bench for dmem_arbiter with reference model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 16;
`ifdef DMEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          host_lock = 1'b0;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter_if #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) core_bus ();
  dmem_arbiter_if #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) host_bus ();

  dmem_arbiter #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .core      (core_bus),
    .host      (host_bus),
`ifdef DMEM_ARB_LOCK_EN
    .host_lock (host_lock),
`endif
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, 256 words populated.
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  // Reference model: memory contents in grant order plus a queue of reads due.
  typedef struct {
    int            due;
    bit            port;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] shadow [0:255];
  rd_t           pend [$];
  int            edge_n = 0;
  bit            rr_host;
  bit            locked;
  bit            e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] e_rdata [2];
  bit            e_rv [2];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    rr_host = 1'b1;
    locked  = 1'b0;
    pend.delete();
    e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    e_rv[0] = 0; e_rv[1] = 0;
    e_rdata[0] = '0; e_rdata[1] = '0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, " mem_en"},      mem_en,          e_en);
    check({pfx, " mem_we"},      mem_we,          e_we);
    check({pfx, " mem_addr"},    mem_addr,        e_addr);
    check({pfx, " mem_wdata"},   mem_wdata,       e_wdata);
    check({pfx, " core_rvalid"}, core_bus.rvalid, e_rv[0]);
    check({pfx, " host_rvalid"}, host_bus.rvalid, e_rv[1]);
    check({pfx, " core_rdata"},  core_bus.rdata,  e_rdata[0]);
    check({pfx, " host_rdata"},  host_bus.rdata,  e_rdata[1]);
  endtask

  // Called at posedge+1; asserts reset, checks outputs, releases after n edges.
  task automatic do_reset(input int cycles);
    rst = 1'b0;
    #1;
    model_reset();
    check("rst core_gnt", core_bus.gnt, 0);
    check("rst host_gnt", host_bus.gnt, 0);
    check_outputs("rst");
    repeat (cycles) @(posedge clk);
    edge_n += cycles;
    #1;
    check_outputs("rst_hold");
    rst = 1'b1;
  endtask

  // One clock: check grants mid-cycle, advance the model at the edge, check after it.
  task automatic step();
    bit gc, gh, p, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    if (locked) begin
      gc = 0; gh = host_bus.req;
    end else if (core_bus.req && host_bus.req) begin
      gc = rr_host; gh = !rr_host;
    end else begin
      gc = core_bus.req; gh = host_bus.req;
    end
    check("core_gnt", core_bus.gnt, gc);
    check("host_gnt", host_bus.gnt, gh);
    @(posedge clk);
    edge_n++;
    e_rv[0] = 0; e_rv[1] = 0;
    if (gc || gh) begin
      p  = gh;
      wr = p ? host_bus.wr    : core_bus.wr;
      a  = p ? host_bus.addr  : core_bus.addr;
      d  = p ? host_bus.wdata : core_bus.wdata;
      e_en = 1; e_we = wr; e_addr = a; e_wdata = d;
      if (wr) shadow[a[7:0]] = d;
      else    pend.push_back('{due: edge_n + 2, port: p, data: shadow[a[7:0]]});
      rr_host = p;
    end else begin
      e_en = 0; e_we = 0;
    end
    if (LOCK_EN) begin
      if (locked) begin
        if (!host_lock) locked = 0;
      end else if (gh && host_lock) begin
        locked = 1;
      end
    end
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      e_rv[pend[0].port]    = 1;
      e_rdata[pend[0].port] = pend[0].data;
      void'(pend.pop_front());
    end
    #1;
    check_outputs("cyc");
  endtask

  task automatic cyc(input bit creq, input bit cwr, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                     input bit hreq, input bit hwr, input logic [AW-1:0] haddr, input logic [DW-1:0] hwd,
                     input bit hl);
    core_bus.req = creq; core_bus.wr = cwr; core_bus.addr = caddr; core_bus.wdata = cwd;
    host_bus.req = hreq; host_bus.wr = hwr; host_bus.addr = haddr; host_bus.wdata = hwd;
    host_lock = hl;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 32'h5A00_0000 | (i * 32'h0001_0101);
      shadow[i] = 32'h5A00_0000 | (i * 32'h0001_0101);
    end
    ram[16] = 32'hDEAD_BEEF; shadow[16] = 32'hDEAD_BEEF;
    core_bus.req = 0; core_bus.wr = 0; core_bus.addr = '0; core_bus.wdata = '0;
    host_bus.req = 0; host_bus.wr = 0; host_bus.addr = '0; host_bus.wdata = '0;

    @(posedge clk);
    #1;
    core_bus.req = 1; host_bus.req = 1;
    do_reset(2);

    // Core-only read of DEADBEEF.
    cyc(1, 0, 16'h0010, '0, 0, 0, '0, '0, 0);
    idle(3);

    // Continuous conflicting reads from reset: C,H,C,H,C,H.
    core_bus.req = 0; host_bus.req = 0;
    do_reset(1);
    for (int i = 0; i < 6; i++)
      cyc(1, 0, 16'(i), '0, 1, 0, 16'(i + 8), '0, 0);
    idle(3);

    // Host write followed by core read of the same word.
    cyc(0, 0, '0, '0, 1, 1, 16'h0004, 32'h1234_5678, 0);
    cyc(1, 0, 16'h0004, '0, 0, 0, '0, '0, 0);
    idle(3);

    // Host lock: core starved while held, then granted once released.
    cyc(0, 0, '0, '0, 1, 0, 16'h0002, '0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 16'h0003, '0, 0, 0, '0, '0, 1);
    cyc(1, 0, 16'h0003, '0, 0, 0, '0, '0, 0);
    cyc(1, 0, 16'h0003, '0, 0, 0, '0, '0, 0);
    idle(3);

    // Core request withdrawn while host holds the lock, then a conflict.
    cyc(0, 0, '0, '0, 1, 0, 16'h0005, '0, 1);
    cyc(1, 1, 16'h0006, 32'hBAD0_BAD0, 0, 0, '0, '0, 1);
    cyc(0, 0, '0, '0, 0, 0, '0, '0, 1);
    cyc(0, 0, '0, '0, 0, 0, '0, '0, 0);
    cyc(1, 0, 16'h0006, '0, 1, 0, 16'h0007, '0, 0);
    idle(3);

    // Reset one cycle after a core read transfer discards that read.
    cyc(1, 0, 16'h0010, '0, 0, 0, '0, '0, 0);
    core_bus.req = 1; host_bus.req = 1;
    do_reset(1);
    idle(3);
    cyc(1, 0, 16'h0001, '0, 1, 0, 16'h0009, '0, 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 15)), $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 15)), $urandom,
          $urandom_range(0, 3) == 0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port synchronous data memory between the instruction execution unit (core port) and the host debug/loader port (host port). It grants one access per cycle with round-robin fairness and drives the memory with registered signals. Read data returns to the issuing requester with a fixed latency. It sits between the core, the debug bridge and the data RAM, and replaces the direct core-to-RAM connection.

## Interface
- DATA_WIDTH, 32, data word width
- DATA_ADDR_WIDTH, 16, word address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- core_req  in  1  core access request
- core_wr  in  1  1 = write, 0 = read
- core_addr  in  DATA_ADDR_WIDTH  core address
- core_wdata  in  DATA_WIDTH  core write data
- core_gnt  out  1  combinational; transfer when core_req && core_gnt at an edge
- core_rvalid  out  1  one-cycle pulse, core read data valid
- core_rdata  out  DATA_WIDTH  core read data, registered
- host_req, host_wr, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same as core_* for the host port
- host_lock  in  1  present only with DMEM_ARB_LOCK_EN; request exclusive ownership
- mem_en  out  1  registered memory enable
- mem_we  out  1  registered write enable
- mem_addr  out  DATA_ADDR_WIDTH  registered address
- mem_wdata  out  DATA_WIDTH  registered write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after mem_en && !mem_we

## Operation
- Requester holds req/wr/addr/wdata stable until its transfer edge (req && gnt).
- Grant, combinational, in state OPEN:
  - one request: that requester wins.
  - both: the requester not in rr_last wins.
  - rr_last updates to the winner on every transfer.
- At most one gnt is high in any cycle. gnt never goes high without the matching req.
- On a transfer edge, mem_en=1 and mem_we/mem_addr/mem_wdata are loaded from the winner. With no transfer, mem_en=0 and mem_we=0; addr and wdata hold.
- Read return pipeline: stage 1 tag {valid, port} is set at the transfer edge for reads. Stage 2 captures mem_rdata into the tagged port's rdata and pulses its rvalid. The other port's rdata holds its value.
- Writes produce no rvalid.
- Sustained throughput is one access per cycle. Reads and writes may be interleaved freely. Memory order equals grant order.
- Lock FSM (macro only): states OPEN and LOCKED.
  - OPEN→LOCKED on a host transfer with host_lock=1.
  - In LOCKED, core_gnt=0 and host_gnt=host_req.
  - LOCKED→OPEN at the first edge with host_lock=0.
  - In-flight core reads still complete.

## Timing
- Read latency: transfer at edge E → mem_en high E..E+1 → rvalid high and rdata valid in the cycle after edge E+2 (2 cycles).
- A write at E is visible to a read granted at E+1 or later.
- Reset (rst=0, asynchronous):
  - all outputs 0: gnt is 0 because it is combinationally gated by reset.
  - rr_last=HOST, so the core wins the first conflict.
  - FSM=OPEN.
  - pipeline tags cleared.
- Reset mid-read: the in-flight read is discarded, and no rvalid appears after reset release.
- First edge after rst deasserts: arbitration is normal.
- Simultaneous requests every cycle: grants strictly alternate.
- A request dropped before its transfer is treated as never issued. No state changes.

## Configuration
- DMEM_ARB_LOCK_EN defined: the host_lock port and the LOCKED state exist, and the host can hold exclusive access for multi-word load/dump.
- DMEM_ARB_LOCK_EN undefined: no host_lock port, the FSM is fixed at OPEN, and arbitration is pure round-robin.

## Test plan
- Core-only read of addr 0x0010 (RAM=0xDEADBEEF): core_gnt is high the same cycle, and core_rvalid pulses 2 cycles after the transfer with core_rdata=0xDEADBEEF. host_rvalid stays 0.
- Both ports request reads continuously for 6 cycles from reset: grants go C,H,C,H,C,H and each rvalid returns its own port's data 2 cycles after its grant.
- Host writes 0x12345678 to 0x0004, then the core reads 0x0004 on the next cycle: the core receives 0x12345678. mem_we is 1 then 0 on consecutive cycles.
- Lock (macro defined): host transfer with host_lock=1, then core_req held high for 5 cycles: core_gnt stays 0 while host_lock=1. The core is granted on the first cycle after host_lock drops.
- Assert rst for 1 cycle the cycle after a core read transfer: all outputs go 0 immediately, and no core_rvalid appears afterwards. The next simultaneous request grants the core.
- Core req raised then dropped while the host holds the lock: no transfer, no mem_en, and rr_last unchanged.
